// File: rtl/itof_pipe.sv
// Three-stage pipelined signed 32-bit integer to IEEE-754 single converter.
// Stages: magnitude/sign, normalise, round/pack; valid/ready on both sides.
module itof_pipe #(
    parameter bit RNE = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [31:0] x,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [31:0] y
);

    logic        r_v1, r_v2, r_v3;
    logic        r_s1_s, r_s1_z;
    logic [31:0] r_s1_m;
    logic        r_s2_s, r_s2_z;
    logic [4:0]  r_s2_lz;
    logic [31:0] r_s2_norm;
    logic [31:0] r_y;

    logic        w_ld3, w_adv2, w_adv1, w_x_fire;
    logic [4:0]  w_lz;
    logic [31:0] w_norm;
    logic [22:0] w_frac;
    logic        w_g, w_st, w_inc;
    logic [23:0] w_sum;
    logic [7:0]  w_exp;
    logic [31:0] w_y;

    // Ready ripples back from the output so bubbles anywhere in the pipe collapse.
    assign w_ld3    = !r_v3 || y_ready;
    assign w_adv2   = !r_v2 || w_ld3;
    assign w_adv1   = !r_v1 || w_adv2;
    assign x_ready  = w_adv1;
    assign w_x_fire = x_valid && w_adv1;

    assign y_valid = r_v3;
    assign y       = r_y;

    always_comb begin
        w_lz = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (r_s1_m[i]) w_lz = 5'(31 - i);
        end
    end

    assign w_norm = r_s1_m << w_lz;

    assign w_frac = r_s2_norm[30:8];
    assign w_g    = r_s2_norm[7];
    assign w_st   = |r_s2_norm[6:0];
    assign w_inc  = RNE && w_g && (w_st || w_frac[0]);
    assign w_sum  = {1'b0, w_frac} + {23'd0, w_inc};
    // A mantissa carry bumps the exponent; the fraction wraps to zero on its own.
    assign w_exp  = 8'd158 - {3'd0, r_s2_lz} + {7'd0, w_sum[23]};
    assign w_y    = r_s2_z ? 32'h0000_0000 : {r_s2_s, w_exp, w_sum[22:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_y  <= 32'h0000_0000;
        end else begin
            if (w_adv1) r_v1 <= x_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_ld3) begin
                r_v3 <= r_v2;
                if (r_v2) r_y <= w_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_x_fire) begin
            r_s1_s <= x[31];
            r_s1_z <= (x == 32'd0);
            r_s1_m <= x[31] ? (~x + 32'd1) : x;
        end
        if (w_adv2 && r_v1) begin
            r_s2_s    <= r_s1_s;
            r_s2_z    <= r_s1_z;
            r_s2_lz   <= w_lz;
            r_s2_norm <= w_norm;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed and random checks of itof_pipe; RNE=1 and RNE=0 instances share stimulus.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        x_valid = 1'b0;
    logic        y_ready = 1'b1;
    logic [31:0] x = 32'd0;
    logic        x_ready, y_valid, x_ready_tz, y_valid_tz;
    logic [31:0] y, y_tz;

    always #5 clk = ~clk;

    itof_pipe #(.RNE(1'b1)) dut (
        .clk(clk), .rstn(rstn), .x_valid(x_valid), .x_ready(x_ready), .x(x),
        .y_valid(y_valid), .y_ready(y_ready), .y(y)
    );

    itof_pipe #(.RNE(1'b0)) dut_tz (
        .clk(clk), .rstn(rstn), .x_valid(x_valid), .x_ready(x_ready_tz), .x(x),
        .y_valid(y_valid_tz), .y_ready(y_ready), .y(y_tz)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_out = 0;
    int bp_base = 0;
    bit chk_lat = 1'b0;
    bit verbose = 1'b1;
    bit held = 1'b0;
    bit rnd_done = 1'b0;
    logic [31:0] held_y = 32'd0;
    logic [31:0] rv;
    logic [31:0] exp1_q[$];
    logic [31:0] exp0_q[$];
    int          acc_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, want);
        end
    endtask

    // Independent reference: locate the MSB, then round the discarded remainder.
    function automatic logic [31:0] ref_f(input logic [31:0] v, input bit rne);
        logic [63:0] m, q, r, half;
        logic        s;
        int          p, sh;
        if (v == 32'd0) return 32'd0;
        s = v[31];
        m = s ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        p = 0;
        for (int i = 0; i < 64; i++) if (m[i]) p = i;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rne && (r > half || (r == half && q[0]))) q = q + 64'd1;
            if (q[24]) begin
                q = q >> 1;
                p = p + 1;
            end
        end
        return {s, 8'(p + 127), q[22:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [31:0] e1, e0;
        int          a;
        if (rstn) begin
            if (held) begin
                chk("hold_v", {31'd0, y_valid}, 32'd1);
                chk("hold_y", y, held_y);
            end
            held   = y_valid && !y_ready;
            held_y = y;
            if (y_valid && y_ready) begin
                n_out++;
                if (exp1_q.size() == 0) begin
                    chk("spurious_y", {31'd0, y_valid}, 32'd0);
                end else begin
                    e1 = exp1_q.pop_front();
                    e0 = exp0_q.pop_front();
                    a  = acc_cyc_q.pop_front();
                    chk("y", y, e1);
                    chk("y_tz", y_tz, e0);
                    chk("tz_v", {31'd0, y_valid_tz}, 32'd1);
                    if (chk_lat) chk("lat", 32'(cyc - a), 32'd3);
                    if (verbose) $display("xfer cyc=%0d y=%08h y_tz=%08h", cyc, y, y_tz);
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic [31:0] e1, input logic [31:0] e0);
        int t;
        x       = v;
        x_valid = 1'b1;
        t       = 0;
        @(negedge clk);
        while (!x_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!x_ready) begin
            chk("send_timeout", {31'd0, x_ready}, 32'd1);
            x_valid = 1'b0;
            return;
        end
        exp1_q.push_back(e1);
        exp0_q.push_back(e0);
        acc_cyc_q.push_back(cyc);
        n_acc++;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        y_ready = 1'b1;
        t = 0;
        while (exp1_q.size() > 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("drain_empty", 32'(exp1_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_yv", {31'd0, y_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_xr", {31'd0, x_ready}, 32'd1);

        // back-to-back basics, extremes and rounding ties
        chk_lat = 1'b1;
        send(32'd1,          32'h3F80_0000, 32'h3F80_0000);
        send(32'hFFFF_FFFF,  32'hBF80_0000, 32'hBF80_0000);
        send(32'd0,          32'h0000_0000, 32'h0000_0000);
        send(32'h0000_0300,  32'h4440_0000, 32'h4440_0000);
        send(32'h8000_0000,  32'hCF00_0000, 32'hCF00_0000);
        send(32'h7FFF_FFFF,  32'h4F00_0000, 32'h4EFF_FFFF);
        send(32'd16777217,   32'h4B80_0000, 32'h4B80_0000);
        send(32'd16777219,   32'h4B80_0002, 32'h4B80_0001);
        send(32'd16777218,   32'h4B80_0001, 32'h4B80_0001);
        send(-32'sd16777219, 32'hCB80_0002, 32'hCB80_0001);
        drain();
        chk_lat = 1'b0;

        // backpressure: stall output while streaming 8 operands
        y_ready = 1'b0;
        bp_base = n_acc;
        fork
            begin
                send(32'd1, 32'h3F80_0000, 32'h3F80_0000);
                send(32'd2, 32'h4000_0000, 32'h4000_0000);
                send(32'd3, 32'h4040_0000, 32'h4040_0000);
                send(32'd4, 32'h4080_0000, 32'h4080_0000);
                send(32'd5, 32'h40A0_0000, 32'h40A0_0000);
                send(32'd6, 32'h40C0_0000, 32'h40C0_0000);
                send(32'd7, 32'h40E0_0000, 32'h40E0_0000);
                send(32'd8, 32'h4100_0000, 32'h4100_0000);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                chk("bp_xr", {31'd0, x_ready}, 32'd0);
                chk("bp_acc", 32'(n_acc - bp_base), 32'd3);
                chk("bp_yv", {31'd0, y_valid}, 32'd1);
                chk("bp_y", y, 32'h3F80_0000);
                y_ready = 1'b1;
            end
        join
        drain();

        // bubbles between operands
        send(32'hFFFF_FFFE, 32'hC000_0000, 32'hC000_0000);
        @(posedge clk); #1;
        send(32'd10, 32'h4120_0000, 32'h4120_0000);
        @(posedge clk); #1;
        send(32'd100, 32'h42C8_0000, 32'h42C8_0000);
        @(posedge clk); #1;
        send(-32'sd100, 32'hC2C8_0000, 32'hC2C8_0000);
        drain();

        // asynchronous reset with three operands in flight
        send(32'd1, 32'h3F80_0000, 32'h3F80_0000);
        send(32'd2, 32'h4000_0000, 32'h4000_0000);
        send(32'd3, 32'h4040_0000, 32'h4040_0000);
        chk("pre_rst_v", {31'd0, y_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_yv", {31'd0, y_valid}, 32'd0);
        chk("arst_y", y, 32'd0);
        n_acc = n_acc - exp1_q.size();
        exp1_q.delete();
        exp0_q.delete();
        acc_cyc_q.delete();
        held = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("post_rst_xr", {31'd0, x_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_yv", {31'd0, y_valid}, 32'd0);
        chk_lat = 1'b1;
        send(32'h0000_0300, 32'h4440_0000, 32'h4440_0000);
        drain();
        chk_lat = 1'b0;

        // random operands with random output stalls
        verbose = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    rv = $urandom;
                    case (i % 4)
                        1: rv = rv >> $urandom_range(0, 31);
                        2: rv = -(rv >> $urandom_range(0, 31));
                        3: rv = (rv & 32'hFF00_0000) | 32'h0000_0080 << $urandom_range(0, 8);
                        default: ;
                    endcase
                    send(rv, ref_f(rv, 1'b1), ref_f(rv, 1'b0));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    y_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("count", 32'(n_out), 32'(n_acc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
